serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Parallel-in, serial-out frame transmitter that feeds bit-serial data into a dynamic (tap-selectable) shift register. It accepts a parallel word over a valid/ready handshake and emits 1 to WIDTH bits, one bit per clock. Its `SO`/`SO_en` outputs connect directly to the `SI`/`clken` inputs of the downstream shift register. Back-to-back frames are sent with no gap cycles, and a `hold` input stalls shifting mid-frame.

## Interface
- `WIDTH`, 8: maximum frame length in bits and width of `din`.
- `LW`, 3: width of `nbits`; must equal clog2(WIDTH).

Ports:
- `clk` in 1: sole clock; every flop is rising-edge triggered.
- `rst` in 1: asynchronous, active-low reset.
- `din` in WIDTH: parallel frame data. Only bits [nbits:0] are transmitted.
- `nbits` in LW: frame length minus 1. A value of 0 sends 1 bit; WIDTH-1 sends WIDTH bits. Sampled on accept.
- `din_valid` in 1: `din`/`nbits` are valid.
- `din_ready` out 1: the block can accept a frame this cycle.
- `hold` in 1: freezes shifting while high.
- `SO` out 1: serial data out, intended to drive downstream `SI`.
- `SO_en` out 1: qualifies `SO`, intended to drive downstream `clken`.
- `frame_done` out 1: one-cycle strobe marking the cycle that carries the last bit of a frame.

## Operation
- Registers:
  - state: IDLE or SHIFT.
  - `shreg[WIDTH-1:0]`.
  - `cnt[LW-1:0]`: bits remaining minus 1.
- Reset (async, `rst`=0): state=IDLE, `shreg`=0, `cnt`=0. Resulting outputs: `SO`=0, `SO_en`=0, `frame_done`=0, `din_ready`=1. No accept can occur while `rst`=0.
- Accept condition: `din_valid && din_ready` at a rising edge. On accept:
  - `cnt` <= `nbits`.
  - state <= SHIFT.
  - `shreg` <= `din` << (WIDTH-1-`nbits`). This MSB-aligns the frame so `din[nbits]` is sent first.
- In SHIFT with `hold`=0, each edge shifts `shreg` left by 1 with zero fill and decrements `cnt`.
- In SHIFT with `cnt`=0 and `hold`=0 (the last bit):
  - If an accept occurs, reload and stay in SHIFT.
  - Otherwise go to IDLE.
- In SHIFT with `hold`=1, `shreg`, `cnt` and state are all frozen.
- Output decode (registered state only, no input-to-output combinational paths except through `hold`):
  - `SO` = (state==SHIFT) & `shreg[WIDTH-1]`; it is 0 in IDLE.
  - `SO_en` = (state==SHIFT) & !`hold`.
  - `frame_done` = (state==SHIFT) & (`cnt`==0) & !`hold`.
  - `din_ready` = (state==IDLE) | `frame_done`.
- Boundary conditions:
  - `din_valid` while busy (`cnt`≠0) is ignored. The source holds `din_valid` until it sees `din_ready`.
  - `nbits` values ≥ WIDTH cannot occur when WIDTH=2^LW. No other range check is performed.
  - `hold` in IDLE has no effect; accepts still proceed.
  - Reset asserted mid-frame aborts the frame immediately (asynchronously). No partial `frame_done` is produced.

## Timing
- Latency: if a frame is accepted at edge k, bit i (0-based) is presented on `SO` with `SO_en`=1 in cycle k+1+i, assuming no hold.
- A frame of N bits occupies exactly N `SO_en` cycles plus one extra cycle for each held cycle.
- `frame_done` is high in the cycle the last bit is presented.
- Back-to-back: an accept in the `frame_done` cycle makes the first bit of the next frame follow in the very next cycle. `SO_en` stays continuously high with zero bubble.
- The downstream register samples `SO` on the same edge at which `SO_en` is high.

## Configuration
- `SERIAL_LSB_FIRST_EN`:
  - When defined: `shreg` is loaded with `din` masked to bits [nbits:0], shifts right, and `SO` = `shreg[0]`. Bits go out as `din[0]` first through `din[nbits]`.
  - When undefined (default): MSB-first as described above.
- The macro changes only bit order; all timing and handshake behaviour is identical.

## Test plan
- Basic MSB-first frame. Reset, then `din`=8'hB2, `nbits`=7, `din_valid` for 1 cycle. Required: `SO`=1,0,1,1,0,0,1,0 over 8 consecutive `SO_en` cycles, `frame_done` on the 8th, then `SO_en`=0 and `din_ready`=1.
- Short frame. `din`=8'h05, `nbits`=2. Required: `SO`=1,0,1 over 3 `SO_en` cycles, with `frame_done` on the 3rd.
- Back-to-back. Hold `din_valid` high with 8'hA5 then 8'h3C, `nbits`=7. Required: 16 contiguous `SO_en` cycles carrying 10100101 00111100, `frame_done` in cycles 8 and 16, and `din_ready` high only in those cycles during the burst.
- Hold mid-frame. Send 8'hB2, `nbits`=7, and assert `hold` for 2 cycles during bit 3. Required: `SO_en`=0 for those 2 cycles with `SO` steady at 1, then the remaining bits 0,0,1,0 follow; the frame spans 10 cycles.
- Reset mid-frame. Pull `rst` low during bit 4 of 8'hFF. Required: `SO`, `SO_en` and `frame_done` go to 0 immediately and `din_ready`=1. After release, a new frame 8'h81 (`nbits`=7) is sent cleanly as 1,0,0,0,0,0,0,1.
- `SERIAL_LSB_FIRST_EN` build. `din`=8'hB2, `nbits`=7. Required: `SO`=0,1,0,0,1,1,0,1 with identical timing.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter feeding a tap-selectable shift register.
// Define SERIAL_LSB_FIRST_EN to send din[0] first; the default build is MSB-first.
module serial_frame_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [LW-1:0]    nbits,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             SO,
  output logic             SO_en,
  output logic             frame_done
);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [LW-1:0]    cnt_q;

  logic             shifting;
  logic             accept;
  logic [LW-1:0]    pad;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] shift_val;

  assign shifting   = (state_q == StShift) && !hold;
  assign frame_done = shifting && (cnt_q == '0);
  assign din_ready  = (state_q == StIdle) || frame_done;
  assign SO_en      = shifting;
  assign accept     = din_valid && din_ready;

  // Number of unused bit positions above the frame's top bit.
  assign pad = LW'(WIDTH - 1) - nbits;

`ifdef SERIAL_LSB_FIRST_EN
  assign load_val  = din & ({WIDTH{1'b1}} >> pad);
  assign shift_val = shreg_q >> 1;
  assign SO        = (state_q == StShift) && shreg_q[0];
`else
  assign load_val  = din << pad;
  assign shift_val = shreg_q << 1;
  assign SO        = (state_q == StShift) && shreg_q[WIDTH-1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      // Covers both an idle accept and a reload on the last bit of a frame.
      state_q <= StShift;
      shreg_q <= load_val;
      cnt_q   <= nbits;
    end else if (shifting) begin
      shreg_q <= shift_val;
      if (cnt_q == '0) begin
        state_q <= StIdle;
      end else begin
        cnt_q <= cnt_q - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed self-checking bench for serial_frame_tx (bit order follows SERIAL_LSB_FIRST_EN).
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic [2:0] nbits = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       hold = 1'b0;
  logic       SO;
  logic       SO_en;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  serial_frame_tx #(.WIDTH(8), .LW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .nbits      (nbits),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .hold       (hold),
    .SO         (SO),
    .SO_en      (SO_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected value of the i-th transmitted bit of an (n+1)-bit frame.
  function automatic logic exp_bit(input logic [7:0] d, input int n, input int i);
`ifdef SERIAL_LSB_FIRST_EN
    return d[i];
`else
    return d[n-i];
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++;
    if (SO !== 1'b0 || SO_en !== 1'b0 || frame_done !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset outputs: got SO=%b en=%b done=%b rdy=%b want 0 0 0 1",
               SO, SO_en, frame_done, din_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    din = 8'hB2; nbits = 3'd7; din_valid = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic ready: got %b want 1", din_ready);
    end
    tick();
    din_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (SO_en !== 1'b1 || SO !== exp_bit(8'hB2, 7, i) || frame_done !== (i == 7)) begin
        errors++;
        $display("FAIL basic bit %0d: got en=%b SO=%b done=%b want 1 %b %b",
                 i, SO_en, SO, frame_done, exp_bit(8'hB2, 7, i), (i == 7));
      end
      tick();
      #1;
    end
    checks++;
    if (SO_en !== 1'b0 || din_ready !== 1'b1 || SO !== 1'b0) begin
      errors++;
      $display("FAIL basic idle: got en=%b rdy=%b SO=%b want 0 1 0", SO_en, din_ready, SO);
    end
  endtask

  task automatic test_short;
    // hold is asserted in idle: the accept must still happen.
    din = 8'h05; nbits = 3'd2; din_valid = 1'b1; hold = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1 || SO_en !== 1'b0) begin
      errors++;
      $display("FAIL short idle-hold: got rdy=%b en=%b want 1 0", din_ready, SO_en);
    end
    tick();
    din_valid = 1'b0; hold = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (SO_en !== 1'b1 || SO !== exp_bit(8'h05, 2, i) || frame_done !== (i == 2)) begin
        errors++;
        $display("FAIL short bit %0d: got en=%b SO=%b done=%b want 1 %b %b",
                 i, SO_en, SO, frame_done, exp_bit(8'h05, 2, i), (i == 2));
      end
      tick();
      #1;
    end
    checks++;
    if (SO_en !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL short idle: got en=%b rdy=%b want 0 1", SO_en, din_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] stream;
    logic        want;
    stream = 16'hA53C;
    din = 8'hA5; nbits = 3'd7; din_valid = 1'b1;
    tick();
    din = 8'h3C;
    #1;
    for (int i = 0; i < 16; i++) begin
`ifdef SERIAL_LSB_FIRST_EN
      want = (i < 8) ? stream[8 + i] : stream[i - 8];
`else
      want = stream[15 - i];
`endif
      checks++;
      if (SO_en !== 1'b1 || SO !== want || frame_done !== (i == 7 || i == 15) ||
          din_ready !== (i == 7 || i == 15)) begin
        errors++;
        $display("FAIL b2b bit %0d: got en=%b SO=%b done=%b rdy=%b want 1 %b %b %b",
                 i, SO_en, SO, frame_done, din_ready, want, (i == 7 || i == 15),
                 (i == 7 || i == 15));
      end
      tick();
      if (i == 7) din_valid = 1'b0;
      #1;
    end
    checks++;
    if (SO_en !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b idle: got en=%b rdy=%b want 0 1", SO_en, din_ready);
    end
  endtask

  task automatic test_hold;
    int  idx;
    logic held;
    din = 8'hB2; nbits = 3'd7; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      held = (c == 3 || c == 4);
      hold = held;
      #1;
      idx = (c < 3) ? c : ((c < 5) ? 3 : c - 2);
      checks++;
      if (SO_en !== !held || SO !== exp_bit(8'hB2, 7, idx) || frame_done !== (c == 9)) begin
        errors++;
        $display("FAIL hold cycle %0d: got en=%b SO=%b done=%b want %b %b %b",
                 c, SO_en, SO, frame_done, !held, exp_bit(8'hB2, 7, idx), (c == 9));
      end
      tick();
    end
    hold = 1'b0;
    #1;
    checks++;
    if (SO_en !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold idle: got en=%b rdy=%b want 0 1", SO_en, din_ready);
    end
  endtask

  task automatic test_reset_mid_frame;
    din = 8'hFF; nbits = 3'd7; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    #1;
    checks++;
    if (SO_en !== 1'b1 || SO !== 1'b1) begin
      errors++;
      $display("FAIL rstmid pre: got en=%b SO=%b want 1 1", SO_en, SO);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (SO !== 1'b0 || SO_en !== 1'b0 || frame_done !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid abort: got SO=%b en=%b done=%b rdy=%b want 0 0 0 1",
               SO, SO_en, frame_done, din_ready);
    end
    tick();
    rst = 1'b1;
    din = 8'h81; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (SO_en !== 1'b1 || SO !== exp_bit(8'h81, 7, i) || frame_done !== (i == 7)) begin
        errors++;
        $display("FAIL rstmid bit %0d: got en=%b SO=%b done=%b want 1 %b %b",
                 i, SO_en, SO, frame_done, exp_bit(8'h81, 7, i), (i == 7));
      end
      tick();
      #1;
    end
    checks++;
    if (SO_en !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid idle: got en=%b rdy=%b want 0 1", SO_en, din_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_back_to_back();
    test_hold();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
